sklansky_subtractor_pipe: RTL and testbench

//   Pipelined WIDTH-bit subtractor with borrow-in/borrow-out: diff = a - b - bin.

---
 rtl/sk_arith_pkg.sv | 17 +
 rtl/sklansky_sub_slice16.sv | 42 ++++
 rtl/sklansky_subtractor_pipe.sv | 112 +++++++++++
 tb/tb_sklansky_subtractor_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sk_arith_pkg.sv
// Shared arithmetic definitions for the sliced parallel-prefix datapaths.
// Slice width, slice-count helper and the per-stage control bundle.
package sk_arith_pkg;

    localparam int SLICE_W = 16;

    // Per-stage control bundle: stage valid flag plus the carry entering that stage's slice.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int slices_for(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/sklansky_sub_slice16.sv
// Combinational 16-bit slice computing s = x + ~y + ci with a Sklansky
// parallel-prefix carry tree; co is the slice carry-out.
module sklansky_sub_slice16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);

    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_pp;
    logic [15:0] w_gg;

    // Prefix tree: each level merges every upper half-block with the top of its lower half-block.
    always_comb begin
        int j;
        j    = 0;
        w_p  = x ^ ~y;
        w_g  = x & ~y;
        w_pp = w_p;
        w_gg = w_g;
        w_gg[0] = w_g[0] | (w_p[0] & ci);
        for (int lvl = 0; lvl < 4; lvl++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i >> lvl) & 1) == 1) begin
                    j = ((i >> lvl) << lvl) - 1;
                    w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[j]);
                    w_pp[i] = w_pp[i] & w_pp[j];
                end else begin
                    w_gg[i] = w_gg[i];
                    w_pp[i] = w_pp[i];
                end
            end
        end
    end

    assign s  = w_p ^ {w_gg[14:0], ci};
    assign co = w_gg[15];

endmodule

// File: rtl/sklansky_subtractor_pipe.sv
// Pipelined WIDTH-bit subtractor (a - b - bin): one 16-bit prefix slice per stage,
// carry passed between stages through registers, valid/ready with a global stall.
module sklansky_subtractor_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import sk_arith_pkg::*;

    localparam int NSTG = slices_for(WIDTH);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_chk
        $error("sklansky_subtractor_pipe: WIDTH must be a non-zero multiple of 16");
    end

    stage_ctl_t       r_ctl [NSTG];
    logic [WIDTH-1:0] r_a   [NSTG];
    logic [WIDTH-1:0] r_b   [NSTG];
    logic [WIDTH-1:0] r_d   [NSTG];

    logic             r_out_vld;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic [15:0]      w_s   [NSTG];
    logic             w_co  [NSTG];
    logic [WIDTH-1:0] w_dn  [NSTG];
    logic             w_advance;
    logic             w_ovf;

    assign w_advance = ~r_out_vld | out_ready;

    for (genvar gk = 0; gk < NSTG; gk++) begin : g_slice
        sklansky_sub_slice16 u_slice (
            .x  (r_a[gk][gk*SLICE_W +: SLICE_W]),
            .y  (r_b[gk][gk*SLICE_W +: SLICE_W]),
            .ci (r_ctl[gk].carry),
            .s  (w_s[gk]),
            .co (w_co[gk])
        );
    end

    // Merge each stage's freshly computed slice into the partial difference it carries.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            w_dn[k] = r_d[k];
            w_dn[k][k*SLICE_W +: SLICE_W] = w_s[k];
        end
    end

    // Signed overflow only when operand signs differ and the result sign departs from a's.
    always_comb begin
        if (r_a[NSTG-1][WIDTH-1] != r_b[NSTG-1][WIDTH-1]) begin
            w_ovf = (w_s[NSTG-1][15] != r_a[NSTG-1][WIDTH-1]);
        end else begin
            w_ovf = 1'b0;
        end
    end

    // Stage registers and output registers, all shifting together on the global advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                r_ctl[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_d[k]   <= '0;
            end
            r_out_vld <= 1'b0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_advance) begin
            r_ctl[0].valid <= in_valid;
            r_ctl[0].carry <= ~bin;
            r_a[0]         <= a;
            r_b[0]         <= b;
            r_d[0]         <= '0;
            for (int k = 1; k < NSTG; k++) begin
                r_ctl[k].valid <= r_ctl[k-1].valid;
                r_ctl[k].carry <= w_co[k-1];
                r_a[k]         <= r_a[k-1];
                r_b[k]         <= r_b[k-1];
                r_d[k]         <= w_dn[k-1];
            end
            r_out_vld <= r_ctl[NSTG-1].valid;
            r_diff    <= w_dn[NSTG-1];
            r_bout    <= ~w_co[NSTG-1];
            r_ovf     <= w_ovf;
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_out_vld;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sklansky_subtractor_pipe.sv
// Bench for sklansky_subtractor_pipe: arithmetic reference model with an ordered
// expectation queue, directed vectors with literal expectations, then random traffic.
module tb_sklansky_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [65:0] q[$];

    sklansky_subtractor_pipe #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, bout, diff} from plain wide unsigned and signed arithmetic.
    function automatic logic [65:0] model(input logic [63:0] va, input logic [63:0] vb, input logic vbin);
        logic [64:0]        u;
        logic signed [65:0] s;
        logic               o;
        u = {1'b0, va} - {1'b0, vb} - {64'd0, vbin};
        s = $signed({{2{va[63]}}, va}) - $signed({{2{vb[63]}}, vb}) - $signed({65'd0, vbin});
        o = !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
        return {o, u[64], u[63:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the outputs are meaningful, compare against the queued expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid) || out_ready});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    chk("diff", diff, q[0][63:0]);
                    chk("bout", {63'd0, bout}, {63'd0, q[0][64]});
                    chk("ovf",  {63'd0, ovf},  {63'd0, q[0][65]});
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, bin));
        end
    end

    task automatic run_one(input string nm, input logic [63:0] va, input logic [63:0] vb, input logic vbin,
                           input logic [63:0] ed, input logic eb, input logic eo);
        logic [65:0] m;
        int lat;
        m = model(va, vb, vbin);
        chk({nm, "_model_diff"}, m[63:0], ed);
        chk({nm, "_model_bout"}, {63'd0, m[64]}, {63'd0, eb});
        chk({nm, "_model_ovf"},  {63'd0, m[65]}, {63'd0, eo});
        @(posedge clk); #1;
        a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) lat = i;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd4);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_bout"}, {63'd0, bout}, {63'd0, eb});
        chk({nm, "_ovf"},  {63'd0, ovf},  {63'd0, eo});
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'h0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        int c;
        int i;
        int n0;
        int sent;
        int cyc;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 64'd0; b = 64'd0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_diff", diff, 64'd0);
        chk("reset_bout", {63'd0, bout}, 64'd0);
        chk("reset_ovf",  {63'd0, ovf},  64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        run_one("basic",    64'h10, 64'h3, 1'b0, 64'hD, 1'b0, 1'b0);
        run_one("wrap",     64'h0,  64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_one("wrap_bin", 64'h0,  64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_one("xslice",   64'h0001_0000_0000_0000, 64'h1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_one("ovf_neg",  64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        run_one("ovf_pos",  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b1, 1'b1);

        // Backpressure: 8 back-to-back operations, downstream stalls in cycles 5..7.
        n0 = n_out; i = 0; c = 0; held = 64'd0;
        while (i < 8 && c < 100) begin
            @(posedge clk); #1;
            out_ready = !(c >= 5 && c <= 7);
            in_valid = 1'b1;
            a = 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h1_0001_0000_0001;
            b = 64'h0000_FFFF_0000_FFFF * 64'(i + 1);
            bin = i[0];
            @(negedge clk);
            if (c == 5) held = diff;
            if (c >= 5 && c <= 7) begin
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                chk("stall_diff_hold", diff, held);
            end
            if (in_ready) i++;
            c++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && (n_out - n0) < 8; k++) @(posedge clk);
        #1 chk("bp_result_count", 64'(n_out - n0), 64'd8);

        // Reset with three operations in flight: none of them may emerge.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 64'(k) + 64'd100; b = 64'd7; bin = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
        end
        run_one("after_rst", 64'h1234, 64'h1235, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

        // Random traffic with gaps on both sides.
        sent = 0; cyc = 0; acc = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                a = rnd_operand();
                b = rnd_operand();
                bin = $urandom_range(0, 1) == 1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_sent", 64'(sent), 64'd10000);
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("rand_drain", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
